line_buf_reader: RTL and testbench



---
 rtl/line_buf_reader_if.sv | 24 ++
 rtl/line_buf_reader.sv | 128 ++++++++++++
 tb/tb_line_buf_reader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_buf_reader_if.sv
// Valid/ready byte stream leaving the line buffer reader.
// The master drives data, valid and last; the slave drives ready.
interface line_buf_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/line_buf_reader.sv
// Line buffer read controller: streams a run of RAM words as valid/ready beats.
// A 2-entry skid FIFO hides the 1-cycle RAM latency to keep full throughput.
module line_buf_reader #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_base,
    input  logic [LEN_WIDTH-1:0]  start_len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    line_buf_reader_if.master     m
);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2 ** ADDR_WIDTH);
    localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t                r_state;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issue;
    logic [LEN_WIDTH-1:0]  r_beats;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wp;
    logic                  r_rp;
    logic [1:0]            r_cnt;

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_head_last;
    logic [2:0]            w_occ;
    logic [LEN_WIDTH-1:0]  w_len;

    assign w_valid     = (r_cnt != 2'd0);
    assign w_pop       = w_valid & m.m_ready;
    assign w_push      = r_inflight;
    assign w_head_last = (r_beats == r_len - ONE);
    // Occupancy once the in-flight word lands and the head possibly leaves.
    assign w_occ       = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_len       = (start_len > MAX_LEN) ? MAX_LEN : start_len;

    assign m.m_data    = r_mem[r_rp];
    assign m.m_valid   = w_valid;
    assign m.m_last    = w_valid & w_head_last;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_issue     <= '0;
            r_beats     <= '0;
            r_inflight  <= 1'b0;
            r_mem[0]    <= '0;
            r_mem[1]    <= '0;
            r_wp        <= 1'b0;
            r_rp        <= 1'b0;
            r_cnt       <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_rd_addr <= '0;
        end else begin
            done  <= 1'b0;
            r_cnt <= w_occ[1:0];
            if (w_push) begin
                r_mem[r_wp] <= ram_rd_data;
                r_wp        <= ~r_wp;
            end
            if (w_pop) begin
                r_rp    <= ~r_rp;
                r_beats <= r_beats + ONE;
            end
            unique case (r_state)
                IDLE: begin
                    r_inflight <= 1'b0;
                    // The done cycle still counts as busy for start.
                    if (start && !done) begin
                        r_len   <= w_len;
                        r_beats <= '0;
                        if (w_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            ram_rd_addr <= start_base;
                            r_inflight  <= 1'b1;
                            r_issue     <= ONE;
                            busy        <= 1'b1;
                            r_state     <= READ;
                        end
                    end
                end
                READ: begin
                    if (r_issue == r_len) begin
                        r_inflight <= 1'b0;
                        r_state    <= DRAIN;
                    end else if (w_occ < 3'd2) begin
                        ram_rd_addr <= ram_rd_addr + 1'b1;
                        r_inflight  <= 1'b1;
                        r_issue     <= r_issue + ONE;
                    end else begin
                        r_inflight <= 1'b0;
                    end
                end
                DRAIN: begin
                    r_inflight <= 1'b0;
                    if (w_pop && w_head_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_inflight <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_line_buf_reader.sv
// Randomized bench for line_buf_reader: a queue model of the expected stream
// is compared against the DUT every cycle, plus directed literal checks.
module tb_line_buf_reader;
    typedef struct {
        logic [7:0] d;
        bit         last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] base = '0;
    logic [11:0] len = '0;
    logic        busy;
    logic        done;
    logic [10:0] addr;
    logic [7:0]  rdata;
    logic [7:0]  mem [2048];

    always #5 clk = ~clk;

    assign rdata = mem[addr];

    line_buf_reader_if #(.DATA_WIDTH(8)) bus ();

    line_buf_reader #(
        .ADDR_WIDTH(11),
        .DATA_WIDTH(8),
        .LEN_WIDTH(12)
    ) dut (
        .rd_clk     (clk),
        .rd_rst     (rst),
        .start      (start),
        .start_base (base),
        .start_len  (len),
        .busy       (busy),
        .done       (done),
        .ram_rd_addr(addr),
        .ram_rd_data(rdata),
        .m          (bus.master)
    );

    int         checks = 0;
    int         errors = 0;
    int         dcount = 0;
    bit         rmode = 1'b0;
    bit         armed = 1'b0;
    bit         rst_chk = 1'b0;
    bit         mb = 1'b0;
    bit         md = 1'b0;
    exp_t       q[$];
    logic [7:0] got[$];
    bit         got_last[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        bus.m_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Behavioural model: a start while idle enqueues the whole run.
    always @(negedge clk) begin
        bit nb;
        bit nd;
        int L;
        if (armed) begin
            if (rst_chk) begin
                chk("rst_addr", 32'(addr), 0);
                chk("rst_data", 32'(bus.m_data), 0);
                chk("rst_valid", 32'(bus.m_valid), 0);
                chk("rst_last", 32'(bus.m_last), 0);
                rst_chk = 1'b0;
            end
            chk("busy", 32'(busy), 32'(mb));
            chk("done", 32'(done), 32'(md));
            if (done) dcount++;
            nb = mb;
            nd = 1'b0;
            if (bus.m_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 32'(bus.m_valid), 0);
                end else begin
                    chk("data", 32'(bus.m_data), 32'(q[0].d));
                    chk("last", 32'(bus.m_last), 32'(q[0].last));
                    if (bus.m_ready) begin
                        got.push_back(bus.m_data);
                        got_last.push_back(bus.m_last);
                        if (q[0].last) begin
                            nb = 1'b0;
                            nd = 1'b1;
                        end
                        void'(q.pop_front());
                    end
                end
            end
            if (!mb && !md && start) begin
                L = (len > 12'd2048) ? 2048 : int'(len);
                if (L == 0) nd = 1'b1;
                else nb = 1'b1;
                for (int i = 0; i < L; i++)
                    q.push_back('{mem[11'(int'(base) + i)], i == L - 1});
            end
            if (rst) begin
                nb = 1'b0;
                nd = 1'b0;
                q.delete();
                rst_chk = 1'b1;
            end
            mb = nb;
            md = nd;
        end
    end

    task automatic wait_done(input int lim, output int n);
        n = 0;
        while (done !== 1'b1 && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_timeout", 32'(done), 1);
    endtask

    task automatic run(input logic [10:0] b, input logic [11:0] l,
                       input bit rnd, input bit intrude);
        int n;
        got.delete();
        got_last.delete();
        dcount = 0;
        rmode = rnd;
        @(posedge clk);
        #1;
        start = 1'b1;
        base = b;
        len = l;
        @(posedge clk);
        #1;
        if (intrude) begin
            base = 11'h100;
            len = 12'd8;
            repeat (5) @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_done(20000, n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int bad;
        int L;
        for (int a = 0; a < 2048; a++) mem[a] = 8'(a);
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_addr", 32'(addr), 0);
        chk("reset_data", 32'(bus.m_data), 0);
        chk("reset_valid", 32'(bus.m_valid), 0);
        chk("reset_last", 32'(bus.m_last), 0);
        armed = 1'b1;

        // Test 1: latency and back-to-back beats
        got.delete();
        got_last.delete();
        dcount = 0;
        rmode = 1'b0;
        start = 1'b1;
        base = 11'h010;
        len = 12'd16;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t1_addr0", 32'(addr), 32'h010);
        chk("t1_valid_k", 32'(bus.m_valid), 0);
        chk("t1_busy_k", 32'(busy), 1);
        @(posedge clk);
        #1;
        chk("t1_valid_k1", 32'(bus.m_valid), 1);
        chk("t1_data_k1", 32'(bus.m_data), 32'h10);
        wait_done(200, n);
        chk("t1_done_cycles", 32'(n), 16);
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_beats", 32'(got.size()), 16);
        bad = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== 8'(8'h10 + i) || got_last[i] !== (i == 15)) bad++;
        chk("t1_seq", 32'(bad), 0);
        @(posedge clk);
        #1;
        chk("t1_done_once", 32'(dcount), 1);

        // Test 2: address wrap
        run(11'h7FE, 12'd4, 1'b0, 1'b0);
        chk("t2_beats", 32'(got.size()), 4);
        if (got.size() == 4) begin
            chk("t2_d0", 32'(got[0]), 32'hFE);
            chk("t2_d1", 32'(got[1]), 32'hFF);
            chk("t2_d2", 32'(got[2]), 32'h00);
            chk("t2_d3", 32'(got[3]), 32'h01);
            chk("t2_last3", 32'(got_last[3]), 1);
            chk("t2_last2", 32'(got_last[2]), 0);
        end

        // Test 3: random back-pressure over random memory
        for (int a = 0; a < 2048; a++) mem[a] = 8'($urandom);
        run(11'($urandom), 12'd64, 1'b1, 1'b0);
        chk("t3_beats", 32'(got.size()), 64);
        chk("t3_done_once", 32'(dcount), 1);
        for (int k = 0; k < 6; k++) begin
            L = $urandom_range(1, 200);
            run(11'($urandom), 12'(L), 1'b1, 1'b0);
            chk("rand_beats", 32'(got.size()), 32'(L));
            chk("rand_done_once", 32'(dcount), 1);
        end

        // Test 4: zero length, then single beat
        got.delete();
        dcount = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        len = 12'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t4_done_len0", 32'(done), 1);
        chk("t4_busy_len0", 32'(busy), 0);
        @(posedge clk);
        #1;
        chk("t4_done_fall", 32'(done), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_no_beats", 32'(got.size()), 0);
        run(11'h055, 12'd1, 1'b1, 1'b0);
        chk("t4_one_beat", 32'(got.size()), 1);
        if (got.size() == 1) begin
            chk("t4_one_last", 32'(got_last[0]), 1);
            chk("t4_one_data", 32'(got[0]), 32'(mem[11'h055]));
        end

        // Test 5: start while busy is ignored; oversize length clamps
        run(11'h200, 12'd24, 1'b1, 1'b1);
        chk("t5_ign_beats", 32'(got.size()), 24);
        if (got.size() > 0) chk("t5_ign_first", 32'(got[0]), 32'(mem[11'h200]));
        chk("t5_ign_done", 32'(dcount), 1);
        run(11'h123, 12'd3000, 1'b1, 1'b0);
        chk("t5_clamp_beats", 32'(got.size()), 2048);
        if (got.size() == 2048) chk("t5_clamp_last", 32'(got_last[2047]), 1);
        chk("t5_clamp_done", 32'(dcount), 1);

        // Test 6: reset mid-run, then a clean run
        got.delete();
        dcount = 0;
        rmode = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        base = 11'h040;
        len = 12'd32;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (got.size() < 5 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_reach5", 32'(got.size() >= 5), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_valid0", 32'(bus.m_valid), 0);
        chk("t6_busy0", 32'(busy), 0);
        chk("t6_addr0", 32'(addr), 0);
        repeat (40) @(posedge clk);
        #1;
        chk("t6_no_done", 32'(dcount), 0);
        run(11'h333, 12'd20, 1'b1, 1'b0);
        chk("t6_new_beats", 32'(got.size()), 20);
        if (got.size() > 0) chk("t6_new_first", 32'(got[0]), 32'(mem[11'h333]));

        chk("q_empty_end", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
